// File: rtl/decode_stage.sv
// Decode stage: register file with write-through bypass, immediate generation,
// main control decode, load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ifidINST,
  input  logic [XLEN-1:0] ifidPc,
  input  logic            flush,
  input  logic            wbWrite,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  output logic            pcStall,
  output logic            ifidStall,
  output logic [XLEN-1:0] idexPc,
  output logic [XLEN-1:0] idexRs1Data,
  output logic [XLEN-1:0] idexRs2Data,
  output logic [XLEN-1:0] idexImm,
  output logic [4:0]      idexRs1,
  output logic [4:0]      idexRs2,
  output logic [4:0]      idexRd,
  output logic [2:0]      idexFunct3,
  output logic            idexFunct7b5,
  output logic            idexRegWrite,
  output logic            idexMemRead,
  output logic            idexMemWrite,
  output logic            idexMemToReg,
  output logic            idexBranch,
  output logic            idexJump,
  output logic            idexAluSrc,
  output logic [1:0]      idexAluOp
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpJal   = 7'b1101111;

  logic [XLEN-1:0] rf [NREG];

  logic [6:0]      opcode;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic            uses_rs1, uses_rs2;
  logic            reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src;
  logic [1:0]      alu_op;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            hit_rs1, hit_rs2, load_use, bubble;

  assign opcode  = ifidINST[6:0];
  assign rs2_idx = ifidINST[24:20];
  assign rd_idx  = ifidINST[11:7];
  assign imm     = XLEN'(signed'(imm32));

  // Main control and immediate decode; unknown opcodes decode to a bubble.
  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    imm32      = '0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    rs1_idx    = ifidINST[19:15];
    case (opcode)
      OpR: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OpIAlu: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b11;
        imm32     = {{20{ifidINST[31]}}, ifidINST[31:20]};
        uses_rs1  = 1'b1;
      end
      OpLoad: begin
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        imm32      = {{20{ifidINST[31]}}, ifidINST[31:20]};
        uses_rs1   = 1'b1;
      end
      OpStore: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm32     = {{20{ifidINST[31]}}, ifidINST[31:25], ifidINST[11:7]};
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OpBr: begin
        branch   = 1'b1;
        alu_op   = 2'b01;
        imm32    = {{19{ifidINST[31]}}, ifidINST[31], ifidINST[7], ifidINST[30:25],
                    ifidINST[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpLui: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm32     = {ifidINST[31:12], 12'b0};
        // LUI has no source register; force x0 so the operand reads as zero.
        rs1_idx   = 5'd0;
      end
      OpJal: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        imm32     = {{11{ifidINST[31]}}, ifidINST[31], ifidINST[19:12], ifidINST[20],
                     ifidINST[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Register file reads with write-through bypass; x0 always reads zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_idx != 5'd0) begin
      rs1_data = (wbWrite && wbRd == rs1_idx) ? wbData : rf[rs1_idx];
    end
    if (rs2_idx != 5'd0) begin
      rs2_data = (wbWrite && wbRd == rs2_idx) ? wbData : rf[rs2_idx];
    end
  end

  // Load-use detection against the load currently in ID/EX; flush wins over stall.
  always_comb begin
    hit_rs1   = uses_rs1 && (idexRd == rs1_idx);
    hit_rs2   = uses_rs2 && (idexRd == rs2_idx);
    load_use  = idexMemRead && (idexRd != 5'd0) && (hit_rs1 || hit_rs2);
    pcStall   = load_use && !flush;
    ifidStall = load_use && !flush;
    bubble    = flush || load_use;
  end

  // Register file write port from write-back; x0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (wbWrite && wbRd != 5'd0) begin
      rf[wbRd] <= wbData;
    end
  end

  // ID/EX pipeline register; a bubble zeroes control but still latches data fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idexPc       <= '0;
      idexRs1Data  <= '0;
      idexRs2Data  <= '0;
      idexImm      <= '0;
      idexRs1      <= '0;
      idexRs2      <= '0;
      idexRd       <= '0;
      idexFunct3   <= '0;
      idexFunct7b5 <= 1'b0;
      idexRegWrite <= 1'b0;
      idexMemRead  <= 1'b0;
      idexMemWrite <= 1'b0;
      idexMemToReg <= 1'b0;
      idexBranch   <= 1'b0;
      idexJump     <= 1'b0;
      idexAluSrc   <= 1'b0;
      idexAluOp    <= 2'b00;
    end else begin
      idexPc       <= ifidPc;
      idexRs1Data  <= rs1_data;
      idexRs2Data  <= rs2_data;
      idexImm      <= imm;
      idexRs1      <= rs1_idx;
      idexRs2      <= rs2_idx;
      idexRd       <= rd_idx;
      idexFunct3   <= ifidINST[14:12];
      idexFunct7b5 <= ifidINST[30];
      idexRegWrite <= reg_write  && !bubble;
      idexMemRead  <= mem_read   && !bubble;
      idexMemWrite <= mem_write  && !bubble;
      idexMemToReg <= mem_to_reg && !bubble;
      idexBranch   <= branch     && !bubble;
      idexJump     <= jump       && !bubble;
      idexAluSrc   <= alu_src    && !bubble;
      idexAluOp    <= bubble ? 2'b00 : alu_op;
    end
  end

endmodule
